// File: rtl/mbscore_wb_ctrl.sv
// Writeback controller: sequences ALU->reg, ALU->mem store and mem->reg load ops; rf_we 1 cycle after accept/ack.
// Backpressure: in_ready only in IDLE; a memory op holds the controller until mem_ack or MEM_TIMEOUT cycles elapse.
module mbscore_wb_ctrl #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int MEM_TIMEOUT    = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [1:0]                in_op,
   input  logic [REG_ADDR_WIDTH-1:0] in_rd,
   input  logic [DATA_WIDTH-1:0]     in_alu,
   output logic [1:0]                wb_sel,
   output logic [DATA_WIDTH-1:0]     alu_q,
   output logic                      mem_req,
   output logic                      mem_we,
   input  logic                      mem_ack,
   output logic                      rf_we,
   output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
   output logic                      err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEM  = 2'd1,
      WB   = 2'd2
   } state_t;

   localparam logic [1:0] OP_NOP   = 2'd0;
   localparam logic [1:0] OP_A2R   = 2'd1;
   localparam logic [1:0] OP_A2M   = 2'd2;
   localparam logic [1:0] OP_M2R   = 2'd3;
   localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);

   state_t     state;
   logic [7:0] wait_cnt;
   logic [7:0] wait_cnt_nxt;

   assign wait_cnt_nxt = wait_cnt + 8'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         in_ready <= 1'b1;
         wb_sel   <= OP_NOP;
         alu_q    <= '0;
         mem_req  <= 1'b0;
         mem_we   <= 1'b0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         err      <= 1'b0;
         wait_cnt <= 8'd0;
      end else begin
         rf_we <= 1'b0;
         err   <= 1'b0;
         case (state)
            IDLE: begin
               // NOP is consumed without touching any output
               if (in_valid && in_op != OP_NOP) begin
                  wb_sel   <= in_op;
                  alu_q    <= in_alu;
                  rf_waddr <= in_rd;
                  in_ready <= 1'b0;
                  wait_cnt <= 8'd0;
                  if (in_op == OP_A2R) begin
                     state <= WB;
                     rf_we <= (in_rd != '0);
                  end else begin
                     state   <= MEM;
                     mem_req <= 1'b1;
                     mem_we  <= (in_op == OP_A2M);
                  end
               end
            end
            MEM: begin
               // ack wins over a timeout landing in the same cycle
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (mem_we) begin
                     state    <= IDLE;
                     wb_sel   <= OP_NOP;
                     in_ready <= 1'b1;
                  end else begin
                     state <= WB;
                     rf_we <= (rf_waddr != '0);
                  end
               end else if (wait_cnt_nxt == TIMEOUT) begin
                  state    <= IDLE;
                  mem_req  <= 1'b0;
                  mem_we   <= 1'b0;
                  wb_sel   <= OP_NOP;
                  in_ready <= 1'b1;
                  err      <= 1'b1;
                  wait_cnt <= wait_cnt_nxt;
               end else begin
                  wait_cnt <= wait_cnt_nxt;
               end
            end
            WB: begin
               state    <= IDLE;
               wb_sel   <= OP_NOP;
               in_ready <= 1'b1;
            end
            default: begin
               state    <= IDLE;
               wb_sel   <= OP_NOP;
               mem_req  <= 1'b0;
               mem_we   <= 1'b0;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/mbscore_wb_ctrl.md
MBSCORE_WB_CTRL -- requirements
Module: mbscore_wb_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, register-file address width.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 15, maximum cycles waiting for mem_ack (range 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  writeback op offered.
REQ-007 SHALL have port in_ready  output  1  controller can accept an op.
REQ-008 SHALL have port in_op  input  2  0=NOP, 1=ALUtoReg, 2=ALUtoMEM, 3=MEMtoReg.
REQ-009 SHALL have port in_rd  input  REG_ADDR_WIDTH  destination register.
REQ-010 SHALL have port in_alu  input  DATA_WIDTH  ALU result (register data or memory address/data).
REQ-011 SHALL have port wb_sel  output  2  select driven to the writeback mux, same encoding as in_op.
REQ-012 SHALL have port alu_q  output  DATA_WIDTH  captured in_alu, held for the whole op.
REQ-013 SHALL have port mem_req  output  1  memory request.
REQ-014 SHALL have port mem_we  output  1  1=store, 0=load; valid while mem_req=1.
REQ-015 SHALL have port mem_ack  input  1  memory completion.
REQ-016 SHALL have port rf_we  output  1  register-file write strobe, one cycle.
REQ-017 SHALL have port rf_waddr  output  REG_ADDR_WIDTH  register write address.
REQ-018 SHALL have port err  output  1  one-cycle pulse on memory timeout.

Function
REQ-019 SHALL implement FSM states IDLE, MEM, WB.
REQ-020 SHALL assert in_ready=1 only in IDLE; accept occurs on in_valid&in_ready at a clock edge, capturing in_op, in_rd, in_alu.
REQ-021 SHALL, on accepting NOP, remain in IDLE with no output activity.
REQ-022 SHALL, on accepting ALUtoReg, enter WB the next cycle: wb_sel=1, rf_we=1, rf_waddr=captured rd for exactly one cycle, then IDLE.
REQ-023 SHALL, on accepting ALUtoMEM, enter MEM: mem_req=1, mem_we=1, wb_sel=2, held until mem_ack=1 sampled; next cycle IDLE with mem_req=0.
REQ-024 SHALL, on accepting MEMtoReg, enter MEM: mem_req=1, mem_we=0, wb_sel=3; on mem_ack enter WB: wb_sel=3, rf_we=1 one cycle, then IDLE.
REQ-025 SHALL keep wb_sel=0 in IDLE and keep wb_sel, alu_q, rf_waddr stable from accept until return to IDLE.
REQ-026 SHALL suppress rf_we when captured rd=0 (WB state still occupies one cycle).
REQ-027 SHALL clear an 8-bit wait counter on MEM entry and increment it each MEM cycle without mem_ack.
REQ-028 SHALL, when the counter reaches MEM_TIMEOUT without ack, drop mem_req, pulse err=1 one cycle, return to IDLE, and perform no rf_we.
REQ-029 SHALL give mem_ack priority over timeout when both occur in the same cycle.
REQ-030 SHALL ignore mem_ack outside MEM.
REQ-031 SHALL give latencies: ALUtoReg rf_we 1 cycle after accept; MEMtoReg rf_we 1 cycle after ack; next accept possible 1 cycle after WB or after store ack.

Reset
REQ-032 SHALL, while rst=1 at a clock edge, enter IDLE and drive in_ready=1, wb_sel=0, mem_req=0, mem_we=0, rf_we=0, err=0, rf_waddr=0, alu_q=0, counter=0.
REQ-033 SHALL abort any in-flight op on reset with no rf_we or err generated; ops presented during reset are not accepted.

Verification
REQ-034 SHALL cover: accept op=1, rd=5, alu=0x1234 -> next cycle rf_we=1, rf_waddr=5, wb_sel=1, alu_q=0x1234; following cycle in_ready=1.
REQ-035 SHALL cover: op=3, rd=7, mem_ack after 3 wait cycles -> mem_req=1, mem_we=0 for 4 cycles, then one cycle rf_we=1, rf_waddr=7, wb_sel=3.
REQ-036 SHALL cover: op=2, alu=0x100, ack never arrives, MEM_TIMEOUT=15 -> mem_req drops after 15 MEM cycles, err pulses once, no rf_we, in_ready=1.
REQ-037 SHALL cover: op=1 with rd=0 -> WB cycle with rf_we=0, then IDLE.
REQ-038 SHALL cover: rst asserted during MEM of a load -> next cycle mem_req=0, wb_sel=0, in_ready=1, no rf_we or err.
REQ-039 SHALL cover: mem_ack coincident with the timeout cycle -> treated as ack, err=0, load writeback occurs.
